elevator_car_ctrl: RTL

- Car-motion controller for the elevator. It consumes the latched hall/cab request vector from the request flip-flop board.
- It runs a SCAN-style (keep direction while work remains) floor-by-floor state machine with travel and door timers.
- It returns one-cycle clear pulses that drive the board's reset_pulse input for each floor served.
- It sits directly downstream of the request board and upstream of motor/door/display logic.

---
 rtl/elevator_car_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/elevator_car_ctrl.sv
// SCAN-style single-car controller: IDLE/MOVE/DOOR with travel and door timers, one-cycle clear pulses per served floor.
// Optional emergency stop (freeze everything, flag estop_active) when ELEVATOR_ESTOP_EN is defined.
module elevator_car_ctrl #(
  parameter int N             = 4,
  parameter int FLOOR_W       = 2,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       req_state,
  input  logic               door_hold,
`ifdef ELEVATOR_ESTOP_EN
  input  logic               estop,
`endif
  output logic [N-1:0]       clear_pulse,
  output logic [FLOOR_W-1:0] cur_floor,
  output logic               dir_up,
  output logic               moving,
  output logic               door_open
`ifdef ELEVATOR_ESTOP_EN
  ,
  output logic               estop_active
`endif
);

  localparam int TW = $clog2(TRAVEL_CYCLES + 1);
  localparam int DW = $clog2(DOOR_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_t;

  state_t             state_q;
  logic [FLOOR_W-1:0] cur_floor_q;
  logic               dir_up_q;
  logic               moving_q;
  logic               door_open_q;
  logic [N-1:0]       clear_pulse_q;
  logic [TW-1:0]      travel_tmr_q;
  logic [DW-1:0]      door_tmr_q;

  function automatic logic bit_at(input logic [N-1:0] v, input logic [FLOOR_W-1:0] f);
    bit_at = 1'b0;
    for (int i = 0; i < N; i++)
      if (int'(f) == i) bit_at = v[i];
  endfunction

  function automatic logic any_beyond(input logic [N-1:0] v, input logic [FLOOR_W-1:0] f,
                                      input logic up);
    any_beyond = 1'b0;
    for (int i = 0; i < N; i++)
      if (v[i] && (up ? (i > int'(f)) : (i < int'(f)))) any_beyond = 1'b1;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [FLOOR_W-1:0] f);
    onehot = '0;
    for (int i = 0; i < N; i++)
      if (int'(f) == i) onehot[i] = 1'b1;
  endfunction

  logic               here, above, below, at_end, arr_here, arr_onward, door_rereq, frozen;
  logic [FLOOR_W-1:0] step_floor_d;

  assign here         = bit_at(req_state, cur_floor_q);
  assign above        = any_beyond(req_state, cur_floor_q, 1'b1);
  assign below        = any_beyond(req_state, cur_floor_q, 1'b0);
  assign step_floor_d = dir_up_q ? cur_floor_q + FLOOR_W'(1) : cur_floor_q - FLOOR_W'(1);
  assign at_end       = dir_up_q ? (int'(cur_floor_q) >= N - 1) : (cur_floor_q == '0);
  assign arr_here     = bit_at(req_state, step_floor_d);
  assign arr_onward   = any_beyond(req_state, step_floor_d, dir_up_q);
  // The board clears one cycle after our pulse, so its still-set bit must not re-trigger.
  assign door_rereq   = here && !bit_at(clear_pulse_q, cur_floor_q);

`ifdef ELEVATOR_ESTOP_EN
  logic estop_active_q;
  assign frozen       = estop;
  assign estop_active = estop_active_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estop_active_q <= 1'b0;
    else        estop_active_q <= estop;
  end
`else
  assign frozen = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cur_floor_q   <= '0;
      dir_up_q      <= 1'b1;
      moving_q      <= 1'b0;
      door_open_q   <= 1'b0;
      clear_pulse_q <= '0;
      travel_tmr_q  <= '0;
      door_tmr_q    <= '0;
    end else begin
      clear_pulse_q <= '0;
      if (!frozen) begin
        case (state_q)
          S_IDLE: begin
            if (here) begin
              state_q       <= S_DOOR;
              door_open_q   <= 1'b1;
              clear_pulse_q <= onehot(cur_floor_q);
              door_tmr_q    <= DW'(DOOR_CYCLES);
            end else if (dir_up_q ? above : below) begin
              state_q      <= S_MOVE;
              moving_q     <= 1'b1;
              travel_tmr_q <= TW'(TRAVEL_CYCLES);
            end else if (dir_up_q ? below : above) begin
              dir_up_q     <= !dir_up_q;
              state_q      <= S_MOVE;
              moving_q     <= 1'b1;
              travel_tmr_q <= TW'(TRAVEL_CYCLES);
            end
          end
          S_MOVE: begin
            if (at_end) begin
              state_q  <= S_IDLE;
              moving_q <= 1'b0;
            end else if (travel_tmr_q <= TW'(1)) begin
              cur_floor_q <= step_floor_d;
              if (arr_here) begin
                state_q       <= S_DOOR;
                moving_q      <= 1'b0;
                door_open_q   <= 1'b1;
                clear_pulse_q <= onehot(step_floor_d);
                door_tmr_q    <= DW'(DOOR_CYCLES);
              end else if (arr_onward) begin
                travel_tmr_q <= TW'(TRAVEL_CYCLES);
              end else begin
                state_q  <= S_IDLE;
                moving_q <= 1'b0;
              end
            end else begin
              travel_tmr_q <= travel_tmr_q - TW'(1);
            end
          end
          S_DOOR: begin
            if (door_rereq) begin
              clear_pulse_q <= onehot(cur_floor_q);
              door_tmr_q    <= DW'(DOOR_CYCLES);
            end else if (door_hold) begin
              door_tmr_q <= DW'(DOOR_CYCLES);
            end else if (door_tmr_q <= DW'(1)) begin
              state_q     <= S_IDLE;
              door_open_q <= 1'b0;
              door_tmr_q  <= '0;
            end else begin
              door_tmr_q <= door_tmr_q - DW'(1);
            end
          end
          default: begin
            state_q     <= S_IDLE;
            moving_q    <= 1'b0;
            door_open_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign clear_pulse = clear_pulse_q;
  assign cur_floor   = cur_floor_q;
  assign dir_up      = dir_up_q;
  assign moving      = moving_q;
  assign door_open   = door_open_q;

endmodule
